// File: rtl/edge_oneshot_pkg.sv
// Shared constants and state encoding for the edge-to-pulse conditioner bank.
package edge_oneshot_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

endpackage

// File: rtl/edge_oneshot_bank_if.sv
// Control/status bundle between the button pins and the game-control logic.
interface edge_oneshot_bank_if #(
  parameter int CHANNELS = 4
);
  logic                en;
  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] level_out;
  logic [CHANNELS-1:0] pulse_out;
  logic                any_pulse;

  modport master (output en, din, input level_out, pulse_out, any_pulse);
  modport slave  (input en, din, output level_out, pulse_out, any_pulse);
endinterface

// File: rtl/edge_oneshot_chan.sv
// One channel: synchroniser, debounce counter, edge detect and hold-to-repeat FSM.
module edge_oneshot_chan
  import edge_oneshot_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = EDGE_RISE,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic level,
  output logic pulse,
  output logic pulse_nxt
);

  localparam int CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW     = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam bit RPT_EN = (REPEAT_DELAY > 0) && (EDGE_MODE != EDGE_BOTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   pulse_q;
  logic                   din_s;
  logic                   toggle;
  logic                   edge_hit;

  rpt_state_t    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rpt_pulse;

  assign din_s  = sync_q[SYNC_STAGES-1];
  // The D-th consecutive mismatching cycle is the one that flips the level.
  assign toggle = (din_s != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign edge_hit = toggle && ((EDGE_MODE == EDGE_BOTH) ||
                               ((EDGE_MODE == EDGE_RISE) && !level_q) ||
                               ((EDGE_MODE == EDGE_FALL) &&  level_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      state_q <= RPT_IDLE;
      rcnt_q  <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      pulse_q <= pulse_nxt;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      if (din_s != level_q) begin
        if (toggle) begin
          level_q <= ~level_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // Any level change while holding means the input left the active level.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    rpt_pulse = 1'b0;
    if (!en || !RPT_EN) begin
      state_d = RPT_IDLE;
    end else begin
      unique case (state_q)
        RPT_IDLE: begin
          if (edge_hit) begin
            state_d = RPT_DELAY;
            rcnt_d  = RW'(REPEAT_DELAY - 1);
          end
        end
        RPT_DELAY, RPT_REPEAT: begin
          if (toggle) begin
            state_d = RPT_IDLE;
          end else if (rcnt_q == '0) begin
            rpt_pulse = 1'b1;
            rcnt_d    = RW'(REPEAT_PERIOD - 1);
            state_d   = RPT_REPEAT;
          end else begin
            rcnt_d = rcnt_q - RW'(1);
          end
        end
        default: state_d = RPT_IDLE;
      endcase
    end
  end

  assign pulse_nxt = en && (edge_hit || rpt_pulse);
  assign level     = level_q;
  assign pulse     = pulse_q;

endmodule

// File: rtl/edge_oneshot_bank.sv
// Multi-channel edge-to-pulse conditioner: CHANNELS independent channels plus a merged pulse flag.
module edge_oneshot_bank
  import edge_oneshot_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = EDGE_RISE,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input logic             clk,
  input logic             rst_n,
  edge_oneshot_bank_if.slave bus
);

  if (EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_BOTH) begin : g_bad_mode
    $error("edge_oneshot_bank: EDGE_MODE must be 0, 1 or 2");
  end
  if (CHANNELS < 1 || CHANNELS > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
      REPEAT_DELAY < 0 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("edge_oneshot_bank: parameter out of range");
  end

  logic [CHANNELS-1:0] level_w;
  logic [CHANNELS-1:0] pulse_w;
  logic [CHANNELS-1:0] pulse_nxt_w;
  logic                any_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    edge_oneshot_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_MODE      (EDGE_MODE),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (bus.en),
      .din      (bus.din[g]),
      .level    (level_w[g]),
      .pulse    (pulse_w[g]),
      .pulse_nxt(pulse_nxt_w[g])
    );
  end

  // Built from the pre-register pulses so it lands in the same cycle as pulse_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_q <= 1'b0;
    else        any_q <= |pulse_nxt_w;
  end

  assign bus.level_out = level_w;
  assign bus.pulse_out = pulse_w;
  assign bus.any_pulse = any_q;

endmodule

// File: tb/tb_edge_oneshot_bank.sv
// Bench for edge_oneshot_bank: four parameter sets driven in parallel against a cycle-level reference model.
module tb_edge_oneshot_bank;

  localparam int NDUT = 4;
  localparam int NCH  = 4;
  localparam int S_A  [NDUT] = '{2, 3, 2, 4};
  localparam int D_A  [NDUT] = '{16, 3, 16, 1};
  localparam int M_A  [NDUT] = '{0, 2, 0, 1};
  localparam int RD_A [NDUT] = '{0, 0, 20, 3};
  localparam int RP_A [NDUT] = '{1, 1, 5, 1};

  logic           clk;
  logic           rst_n;
  logic           en;
  logic [NCH-1:0] din;

  logic [NCH-1:0] got_lvl [NDUT];
  logic [NCH-1:0] got_pls [NDUT];
  logic           got_any [NDUT];

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    edge_oneshot_bank_if #(.CHANNELS(NCH)) ifc ();
    assign ifc.en      = en;
    assign ifc.din     = din;
    assign got_lvl[k]  = ifc.level_out;
    assign got_pls[k]  = ifc.pulse_out;
    assign got_any[k]  = ifc.any_pulse;
    edge_oneshot_bank #(
      .CHANNELS       (NCH),
      .SYNC_STAGES    (S_A[k]),
      .DEBOUNCE_CYCLES(D_A[k]),
      .EDGE_MODE      (M_A[k]),
      .REPEAT_DELAY   (RD_A[k]),
      .REPEAT_PERIOD  (RP_A[k])
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: din history since reset, run length of disagreement,
  // and the time elapsed since the last active edge while the level is held.
  int             edge_n;
  logic [NCH-1:0] hist [8];
  bit             m_lvl  [NDUT][NCH];
  int             m_run  [NDUT][NCH];
  bit             m_held [NDUT][NCH];
  int             m_age  [NDUT][NCH];
  logic [NCH-1:0] e_lvl [NDUT];
  logic [NCH-1:0] e_pls [NDUT];

  task automatic model_reset();
    edge_n = 0;
    for (int i = 0; i < 8; i++) hist[i] = '0;
    for (int k = 0; k < NDUT; k++) begin
      e_lvl[k] = '0;
      e_pls[k] = '0;
      for (int c = 0; c < NCH; c++) begin
        m_lvl[k][c]  = 1'b0;
        m_run[k][c]  = 0;
        m_held[k][c] = 1'b0;
        m_age[k][c]  = 0;
      end
    end
  endtask

  task automatic model_step();
    int n_s;
    edge_n++;
    hist[edge_n[2:0]] = din;
    for (int k = 0; k < NDUT; k++) begin
      n_s = edge_n - S_A[k];
      for (int c = 0; c < NCH; c++) begin
        bit s, tog, hit, rp;
        s   = (n_s >= 1) ? hist[n_s[2:0]][c] : 1'b0;
        tog = 1'b0;
        if (s != m_lvl[k][c]) begin
          m_run[k][c]++;
          if (m_run[k][c] == D_A[k]) begin
            m_lvl[k][c] = ~m_lvl[k][c];
            m_run[k][c] = 0;
            tog = 1'b1;
          end
        end else begin
          m_run[k][c] = 0;
        end
        hit = tog && (M_A[k] == 2 || (M_A[k] == 0 && m_lvl[k][c]) || (M_A[k] == 1 && !m_lvl[k][c]));
        rp  = 1'b0;
        if (m_held[k][c]) begin
          if (!en || tog) m_held[k][c] = 1'b0;
          else begin
            m_age[k][c]++;
            if (m_age[k][c] >= RD_A[k] && (m_age[k][c] - RD_A[k]) % RP_A[k] == 0) rp = 1'b1;
          end
        end else if (en && hit && RD_A[k] > 0 && M_A[k] != 2) begin
          m_held[k][c] = 1'b1;
          m_age[k][c]  = 0;
        end
        e_lvl[k][c] = m_lvl[k][c];
        e_pls[k][c] = en && (hit || rp);
      end
    end
  endtask

  task automatic check_outputs(input string pre);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s_lvl%0d", pre, k), 32'(got_lvl[k]), 32'(e_lvl[k]));
      check($sformatf("%s_pls%0d", pre, k), 32'(got_pls[k]), 32'(e_pls[k]));
      check($sformatf("%s_any%0d", pre, k), 32'(got_any[k]), 32'(|e_pls[k]));
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs("cyc");
  endtask

  // Runs n cycles, counting pulses on one channel of one DUT and noting the first one (1-based, 0 = none).
  task automatic run_n(input int n, input int k, input int c, output int cnt, output int first);
    cnt   = 0;
    first = 0;
    for (int i = 1; i <= n; i++) begin
      run_cycle();
      if (got_pls[k][c]) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("arst");
    @(negedge clk);
    check_outputs("rsthold");
    rst_n = 1'b1;
  endtask

  int cnt, first, cnt2, first2;

  initial begin
    n_chk = 0;
    n_err = 0;
    en    = 1'b1;
    din   = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("rst");
    rst_n = 1'b1;
    run_n(5, 0, 0, cnt, first);

    // Clean rise on channel 0; the repeat DUT pulses at t, t+20, t+25 ... t+55.
    din[0] = 1'b1;
    run_n(17, 0, 0, cnt, first);
    check("pre_accept", 32'(cnt), 32'd0);
    run_n(60, 2, 0, cnt, first);
    check("rpt_first", 32'(first), 32'd1);
    check("rpt_count", 32'(cnt), 32'd9);

    // Dropping en mid-repeat stops the train at once and it does not resume.
    en = 1'b0;
    run_n(1, 2, 0, cnt, first);
    check("en_off_pls", 32'(cnt), 32'd0);
    check("en_off_lvl", 32'(got_lvl[2][0]), 32'd1);
    run_n(5, 2, 0, cnt, first);
    en = 1'b1;
    run_n(15, 2, 0, cnt2, first);
    check("en_no_replay", 32'(cnt + cnt2), 32'd0);
    din[0] = 1'b0;
    run_n(30, 0, 0, cnt, first);
    check("fall_no_pls", 32'(cnt), 32'd0);

    // Bounce on channel 1: high 10, low 3, high 30.
    din[1] = 1'b1;
    run_n(10, 0, 1, cnt, first);
    din[1] = 1'b0;
    run_n(3, 0, 1, cnt2, first);
    check("bounce_burst", 32'(cnt + cnt2), 32'd0);
    din[1] = 1'b1;
    run_n(30, 0, 1, cnt, first);
    check("bounce_cnt", 32'(cnt), 32'd1);
    check("bounce_lat", 32'(first), 32'd18);
    din[1] = 1'b0;
    run_n(25, 0, 1, cnt, first);

    // Both-edge DUT (sync 3, debounce 3): one pulse per edge, 50 cycles apart.
    din[2] = 1'b1;
    run_n(50, 1, 2, cnt, first);
    din[2] = 1'b0;
    run_n(50, 1, 2, cnt2, first2);
    check("both_cnt", 32'(cnt + cnt2), 32'd2);
    check("both_rise_lat", 32'(first), 32'd6);
    check("both_gap", 32'(50 + first2 - first), 32'd50);

    // Reset in the middle of debouncing, then release with the input still high.
    din[3] = 1'b1;
    run_n(8, 0, 3, cnt, first);
    check("pre_rst_lvl", 32'(got_lvl[1][3]), 32'd1);
    async_reset();
    run_n(30, 0, 3, cnt, first);
    check("post_rst_lat", 32'(first), 32'd18);
    check("post_rst_cnt", 32'(cnt), 32'd1);

    // Randomized traffic: slow toggling first so the long debounce accepts, then fast bouncing.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, (i < 1500) ? 29 : 5) == 0) din[c] = ~din[c];
      end
      if (en && $urandom_range(0, 199) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 39) == 0) en = 1'b1;
      if ($urandom_range(0, 999) == 0) async_reset();
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
